conv_encoder_relu_maxpool: RTL

Streaming ReLU plus 2x2/stride-2 max-pooling stage placed directly downstream of the encoder batch-normalization stage. It accepts one normalized signed pixel per qualified cycle in raster order, clamps negatives to zero, and reduces each non-overlapping 2x2 window to its maximum. The result is a half-resolution feature map emitted in raster order for the next encoder convolution. A half-row buffer holds partial maxima, so the block needs no frame storage.

---
 rtl/conv_encoder_relu_maxpool_if.sv | 21 ++
 rtl/conv_encoder_relu_maxpool.sv | 78 +++++++
 2 files changed

// File: rtl/conv_encoder_relu_maxpool_if.sv
// Pixel stream bundle for the encoder ReLU/max-pool stage.
// master drives pixels in, slave produces pooled pixels.
interface conv_encoder_relu_maxpool_if #(
   parameter int WIDTH = 18
);
   logic                    in_valid;
   logic signed [WIDTH-1:0] in_pixel;
   logic signed [WIDTH-1:0] out_pixel;
   logic                    out_valid;
   logic                    frame_done;

   modport master (
      output in_valid, in_pixel,
      input  out_pixel, out_valid, frame_done
   );

   modport slave (
      input  in_valid, in_pixel,
      output out_pixel, out_valid, frame_done
   );
endinterface

// File: rtl/conv_encoder_relu_maxpool.sv
// Streaming ReLU + 2x2/stride-2 max-pool; a half-row buffer
// keeps the top-row partial maxima of each window.
module conv_encoder_relu_maxpool #(
   parameter int WIDTH = 18,
   parameter int IMG_W = 32,
   parameter int IMG_H = 32
) (
   input logic clk,
   input logic rst,
   conv_encoder_relu_maxpool_if.slave bus
);
   localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 1;
   localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 1;
   localparam int LW = (IMG_W > 4) ? $clog2(IMG_W / 2) : 1;
   localparam int LN = IMG_W / 2;

   logic [CW-1:0]    col;
   logic [RW-1:0]    row;
   logic [WIDTH-1:0] h;
   logic [WIDTH-1:0] r;
   logic [WIDTH-1:0] hr;
   logic [WIDTH-1:0] lb [LN];
   logic [CW-1:0]    half;
   logic [LW-1:0]    idx;
   logic             col_last;
   logic             row_last;

   function automatic logic [WIDTH-1:0] max2(
      input logic [WIDTH-1:0] a,
      input logic [WIDTH-1:0] b
   );
      return (a > b) ? a : b;
   endfunction

   // After ReLU every operand is non-negative, so unsigned compare is exact.
   always_comb begin
      r        = bus.in_pixel[WIDTH-1] ? '0 : bus.in_pixel;
      hr       = max2(h, r);
      half     = col >> 1;
      idx      = half[LW-1:0];
      col_last = (col == CW'(IMG_W - 1));
      row_last = (row == RW'(IMG_H - 1));
   end

   always_ff @(posedge clk) begin
      if (!rst && bus.in_valid && col[0] && !row[0])
         lb[idx] <= hr;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         col            <= '0;
         row            <= '0;
         h              <= '0;
         bus.out_pixel  <= '0;
         bus.out_valid  <= 1'b0;
         bus.frame_done <= 1'b0;
      end else begin
         bus.out_valid  <= 1'b0;
         bus.frame_done <= 1'b0;
         if (bus.in_valid) begin
            if (!col[0]) begin
               h <= r;
            end else if (row[0]) begin
               bus.out_pixel  <= max2(lb[idx], hr);
               bus.out_valid  <= 1'b1;
               bus.frame_done <= row_last && col_last;
            end
            if (col_last) begin
               col <= '0;
               row <= row_last ? '0 : row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
         end
      end
   end
endmodule
